// File: rtl/gpio_cond_pkg.sv
// Shared types, constants and helpers for gpio_input_conditioner.
package gpio_cond_pkg;

  // Encodings equal the debounced {INCB, INCA} value of each detent phase.
  typedef enum logic [1:0] {
    REST = 2'b11,
    A    = 2'b10,
    Z    = 2'b00,
    B    = 2'b01
  } quad_state_t;

  localparam logic [1:0] REST_AB = 2'b11;
  // Four sub-steps overflow the 3-bit accumulator, so detents are detected on a widened sum.
  localparam logic signed [3:0] ACC_FULL = 4'sd4;

  localparam logic [15:0] ACCEL_WINDOW = 16'd20000;
  localparam int ACCEL_STEP = 4;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  // +1 for a clockwise sub-step, -1 for counter-clockwise, 0 otherwise.
  function automatic logic signed [1:0] quad_dir(input quad_state_t from, input logic [1:0] to);
    quad_state_t fwd;
    quad_state_t bwd;
    fwd = REST;
    bwd = REST;
    case (from)
      REST:    begin fwd = A;    bwd = B;    end
      A:       begin fwd = Z;    bwd = REST; end
      Z:       begin fwd = B;    bwd = A;    end
      B:       begin fwd = REST; bwd = Z;    end
      default: begin fwd = REST; bwd = REST; end
    endcase
    if (to == fwd)      return 2'sb01;
    else if (to == bwd) return 2'sb11;
    else                return 2'sb00;
  endfunction

endpackage

// File: rtl/gpio_input_conditioner_debounce_bit.sv
// debounce_bit: 2-FF synchroniser followed by a stable-count debouncer for one pin.
module debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int unsigned LIMIT   = 1,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o
);

  localparam int unsigned     CW   = cnt_width(LIMIT);
  localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == LAST) db_d  = sync2_q;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      db_q    <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Board GPIO conditioner: debounce, rotary quadrature decode, position and change interrupt.
// Optional macro GPIO_COND_ROT_ACCEL_EN enables ×4 position steps for fast rotation.
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int unsigned NUM_BTN             = 5,
  parameter int unsigned NUM_SW              = 4,
  parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
  parameter int unsigned ENC_DEBOUNCE_CYCLES = 5000,
  parameter int unsigned POS_W               = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [2:0]         rot_raw,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_SW-1:0]  sw_db,
  output logic [2:0]         rot_db,
  output logic               rot_cw,
  output logic               rot_ccw,
  output logic [POS_W-1:0]   rot_pos,
  output logic               rot_err,
  output logic               irq,
  input  logic               irq_clr
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(.LIMIT(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db (
      .clk_i(aclk), .rst_ni(aresetn), .raw_i(btn_raw[i]), .db_o(btn_db[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(.LIMIT(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db (
      .clk_i(aclk), .rst_ni(aresetn), .raw_i(sw_raw[i]), .db_o(sw_db[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_enc
    debounce_bit #(.LIMIT(ENC_DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db (
      .clk_i(aclk), .rst_ni(aresetn), .raw_i(rot_raw[i]), .db_o(rot_db[i])
    );
  end

  debounce_bit #(.LIMIT(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_push_db (
    .clk_i(aclk), .rst_ni(aresetn), .raw_i(rot_raw[2]), .db_o(rot_db[2])
  );

  quad_state_t        quad_q;
  logic signed [2:0]  acc_q;
  logic [POS_W-1:0]   pos_q;
  logic               cw_q, ccw_q, err_q, irq_q;
  logic [NUM_BTN-1:0] btn_prev_q;
  logic [NUM_SW-1:0]  sw_prev_q;
  logic               push_prev_q;

  logic [1:0]        ab;
  logic              moved, illegal;
  logic signed [1:0] dir;
  logic signed [3:0] acc_sum;
  logic              cw_d, ccw_d, set_evt;
  logic [POS_W-1:0]  step;

  assign ab      = rot_db[1:0];
  assign moved   = (ab != quad_q);
  assign illegal = ((ab ^ quad_q) == 2'b11);
  assign dir     = quad_dir(quad_q, ab);
  assign acc_sum = 4'(acc_q) + 4'(dir);
  assign cw_d    = moved && !illegal && (ab == REST_AB) && (acc_sum == ACC_FULL);
  assign ccw_d   = moved && !illegal && (ab == REST_AB) && (acc_sum == -ACC_FULL);
  assign set_evt = (btn_db != btn_prev_q) || (sw_db != sw_prev_q) ||
                   (rot_db[2] != push_prev_q) || cw_q || ccw_q;

`ifdef GPIO_COND_ROT_ACCEL_EN
  logic [15:0] timer_q;

  always_ff @(posedge aclk) begin
    if (!aresetn)                timer_q <= '0;
    else if (cw_d || ccw_d)      timer_q <= '0;
    else if (timer_q != 16'hFFFF) timer_q <= timer_q + 16'd1;
  end

  assign step = (timer_q < ACCEL_WINDOW) ? POS_W'(ACCEL_STEP) : POS_W'(1);
`else
  assign step = POS_W'(1);
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      quad_q      <= REST;
      acc_q       <= '0;
      pos_q       <= '0;
      cw_q        <= 1'b0;
      ccw_q       <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      btn_prev_q  <= '0;
      sw_prev_q   <= '0;
      push_prev_q <= 1'b0;
    end else begin
      cw_q  <= cw_d;
      ccw_q <= ccw_d;
      if (cw_d)       pos_q <= pos_q + step;
      else if (ccw_d) pos_q <= pos_q - step;

      if (moved) begin
        quad_q <= quad_state_t'(ab);
        if (illegal || ab == REST_AB) acc_q <= '0;
        else                          acc_q <= acc_sum[2:0];
      end

      if (moved && illegal) err_q <= 1'b1;
      else if (irq_clr)     err_q <= 1'b0;

      if (set_evt)      irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;

      btn_prev_q  <= btn_db;
      sw_prev_q   <= sw_db;
      push_prev_q <= rot_db[2];
    end
  end

  assign rot_cw  = cw_q;
  assign rot_ccw = ccw_q;
  assign rot_pos = pos_q;
  assign rot_err = err_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner against a cycle-level behavioural model.
module tb_gpio_input_conditioner;

  localparam int DB  = 8;
  localparam int ENC = 3;
  localparam int H   = ENC + 3;
  localparam logic [11:0] RSTV = 12'h600;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [4:0] btn_raw = 5'h1F;
  logic [3:0] sw_raw = 4'hF;
  logic [2:0] rot_raw = 3'h7;
  logic       irq_clr = 1'b0;
  logic [4:0] btn_db;
  logic [3:0] sw_db;
  logic [2:0] rot_db;
  logic       rot_cw, rot_ccw, rot_err, irq;
  logic [7:0] rot_pos;

  always #5 aclk = ~aclk;

  gpio_input_conditioner #(
    .NUM_BTN(5), .NUM_SW(4), .DEBOUNCE_CYCLES(DB), .ENC_DEBOUNCE_CYCLES(ENC), .POS_W(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .btn_raw(btn_raw), .sw_raw(sw_raw), .rot_raw(rot_raw),
    .btn_db(btn_db), .sw_db(sw_db), .rot_db(rot_db), .rot_cw(rot_cw), .rot_ccw(rot_ccw),
    .rot_pos(rot_pos), .rot_err(rot_err), .irq(irq), .irq_clr(irq_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cw_seen = 0;
  int ccw_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: pins are seen two cycles late; an output follows its pin once the pin
  // has disagreed with it for the full limit; rotary motion is tracked as a
  // phase around the 4-state Gray cycle and a net sub-step count since REST.
  logic [11:0] d1, d2, m_db, m_db_prev;
  int          run [12];
  int          net, since;
  logic [1:0]  last_ab;
  logic        m_cw, m_ccw, m_err, m_irq;
  logic [7:0]  m_pos;

  function automatic int lim(input int b);
    return (b == 9 || b == 10) ? ENC : DB;
  endfunction

  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_step();
    logic        ev, n_cw, n_ccw;
    logic [11:0] seen;
    logic [1:0]  ab;
    int          d, stp;
    if (!aresetn) begin
      d1 = RSTV; d2 = RSTV; m_db = RSTV; m_db_prev = RSTV;
      foreach (run[b]) run[b] = 0;
      net = 0; since = 0; last_ab = 2'b11;
      m_cw = 0; m_ccw = 0; m_err = 0; m_irq = 0; m_pos = 8'd0;
      return;
    end
    ev = (((m_db ^ m_db_prev) & 12'h9FF) != 12'h000) || m_cw || m_ccw;
    if (ev)           m_irq = 1'b1;
    else if (irq_clr) m_irq = 1'b0;
    if (irq_clr) m_err = 1'b0;
    n_cw = 0; n_ccw = 0;
    ab = m_db[10:9];
    if (ab != last_ab) begin
      d = (phase(ab) - phase(last_ab) + 4) % 4;
      if (d == 2) begin
        m_err = 1'b1;
        net = 0;
      end else begin
        net += (d == 1) ? 1 : -1;
        if (ab == 2'b11) begin
          n_cw  = (net == 4);
          n_ccw = (net == -4);
          net = 0;
        end
      end
      last_ab = ab;
    end
    stp = 1;
`ifdef GPIO_COND_ROT_ACCEL_EN
    if (since < 20000) stp = 4;
`endif
    if (n_cw)  m_pos = m_pos + 8'(stp);
    if (n_ccw) m_pos = m_pos - 8'(stp);
    if (n_cw || n_ccw) since = 0;
    else if (since < 65535) since++;
    m_cw = n_cw; m_ccw = n_ccw;
    m_db_prev = m_db;
    seen = d2; d2 = d1; d1 = {rot_raw, sw_raw, btn_raw};
    for (int b = 0; b < 12; b++) begin
      if (seen[b] != m_db[b]) begin
        run[b]++;
        if (run[b] == lim(b)) begin
          m_db[b] = seen[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
    if (rot_cw)  cw_seen++;
    if (rot_ccw) ccw_seen++;
    check("outputs", {8'd0, rot_db, sw_db, btn_db, rot_cw, rot_ccw, rot_pos, rot_err, irq},
          {8'd0, m_db, m_cw, m_ccw, m_pos, m_err, m_irq});
  endtask

  task automatic rot_move(input logic [1:0] ab, input int hold);
    rot_raw[1:0] = ab;
    repeat (hold) tick();
  endtask

  task automatic detent(input logic cw);
    if (cw) begin rot_move(2'b10, H); rot_move(2'b00, H); rot_move(2'b01, H); rot_move(2'b11, H); end
    else    begin rot_move(2'b01, H); rot_move(2'b00, H); rot_move(2'b10, H); rot_move(2'b11, H); end
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  initial begin
    int         hold;
    logic       found;
    logic [7:0] p0;

    repeat (3) tick();
    check("rst_btn", 32'(btn_db), 32'h00);
    check("rst_sw", 32'(sw_db), 32'h0);
    check("rst_rot", 32'(rot_db), 32'h3);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pos", 32'(rot_pos), 32'h0);
    aresetn = 1'b1;
    for (int i = 1; i <= DB + 2; i++) begin
      tick();
      if (i == DB + 1) check("rst_lat_early", 32'(btn_db), 32'h00);
      if (i == DB + 2) check("rst_lat_exact", 32'(btn_db), 32'h1F);
    end

    btn_raw = '0; sw_raw = '0; rot_raw = 3'b011;
    repeat (DB + 6) tick();
    clear_irq();
    check("idle_irq", 32'(irq), 32'h0);

    btn_raw[0] = 1'b1;
    repeat (5) tick();
    btn_raw[0] = 1'b0;
    repeat (DB + 6) tick();
    check("glitch_db", 32'(btn_db[0]), 32'h0);
    check("glitch_irq", 32'(irq), 32'h0);

    cw_seen = 0; ccw_seen = 0;
    detent(1'b1);
    repeat (3) tick();
    check("cw_pulses", 32'(cw_seen), 32'd1);
`ifdef GPIO_COND_ROT_ACCEL_EN
    check("cw_pos", 32'(rot_pos), 32'd4);
`else
    check("cw_pos", 32'(rot_pos), 32'd1);
`endif
    check("cw_irq", 32'(irq), 32'h1);
    detent(1'b0);
    repeat (3) tick();
    check("ccw_pulses", 32'(ccw_seen), 32'd1);
    check("ccw_pos", 32'(rot_pos), 32'd0);

    cw_seen = 0; ccw_seen = 0;
    rot_move(2'b10, H); rot_move(2'b11, H);
    repeat (3) tick();
    check("partial_pulses", 32'(cw_seen + ccw_seen), 32'd0);
    check("partial_pos", 32'(rot_pos), 32'd0);

    rot_move(2'b00, H);
    check("illegal_err", 32'(rot_err), 32'h1);
    rot_move(2'b01, H); rot_move(2'b11, H);
    repeat (3) tick();
    check("illegal_pos", 32'(rot_pos), 32'd0);
    clear_irq();
    check("clr_err", 32'(rot_err), 32'h0);
    check("clr_irq", 32'(irq), 32'h0);

    repeat (127) detent(1'b1);
    rot_move(2'b10, H); rot_move(2'b00, H); rot_move(2'b01, H);
    clear_irq();
    rot_raw[1:0] = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (rot_cw) found = 1'b1;
    end
    check("prio_seen_cw", 32'(found), 32'h1);
    check("prio_pre_irq", 32'(irq), 32'h0);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("prio_irq", 32'(irq), 32'h1);
`ifndef GPIO_COND_ROT_ACCEL_EN
    check("wrap_pos", 32'(rot_pos), 32'h80);
`endif

    for (int it = 0; it < 300; it++) begin
      hold = int'($urandom_range(1, 14));
      case ($urandom_range(0, 5))
        0: btn_raw = btn_raw ^ 5'(1 << $urandom_range(0, 4));
        1: sw_raw  = sw_raw ^ 4'(1 << $urandom_range(0, 3));
        2: rot_raw[2] = ~rot_raw[2];
        3, 4: begin
          rot_raw = rot_raw ^ 3'(1 << $urandom_range(0, 1));
          hold = int'($urandom_range(1, 8));
        end
        default: begin
          rot_raw[1:0] = ~rot_raw[1:0];
          hold = int'($urandom_range(1, 8));
        end
      endcase
      irq_clr = ($urandom_range(0, 7) == 0);
      tick();
      irq_clr = 1'b0;
      repeat (hold - 1) tick();
    end

`ifdef GPIO_COND_ROT_ACCEL_EN
    rot_raw[1:0] = 2'b11;
    repeat (20500) tick();
    p0 = rot_pos;
    detent(1'b1);
    check("accel_first", 32'(8'(rot_pos - p0)), 32'd1);
    repeat (1000) tick();
    detent(1'b1);
    check("accel_fast", 32'(8'(rot_pos - p0)), 32'd5);
    repeat (30000) tick();
    detent(1'b1);
    check("accel_slow", 32'(8'(rot_pos - p0)), 32'd6);
`else
    p0 = rot_pos;
    rot_raw[1:0] = 2'b11;
    repeat (H) tick();
    clear_irq();
    p0 = rot_pos;
    detent(1'b0);
    repeat (2) tick();
    check("rand_ccw_step", 32'(8'(p0 - rot_pos)), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
